// File: rtl/lcd_i2c_byte_tx.sv
// Write-only two-wire (I2C-style) byte transmitter for the LCD backpack.
// Each accepted byte is framed as START, {ADDR,W}, ACK, data, ACK, STOP.
// Bit timing is built from four quarters of QUARTER system clocks each.
// sda_o is open-drain style: 0 pulls the line low, 1 releases it.
// sda_in must already be synchronised by the caller.
module lcd_i2c_byte_tx #(
    parameter int         QUARTER = 8,
    parameter logic [6:0] ADDR    = 7'h27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       scl,
    output logic       sda_o,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       ack_error
);

    localparam int             QW        = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [QW-1:0]  Q_LAST    = QW'(QUARTER - 1);
    // done must be visible during the last clock of STOP q3, so it is
    // registered one clock earlier, when the counter reaches QUARTER-2.
    localparam logic [QW-1:0]  Q_PRE     = QW'(QUARTER - 2);
    localparam logic [7:0]     ADDR_BYTE = {ADDR, 1'b0};

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR_TX,
        ADDR_ACK,
        DATA_TX,
        DATA_ACK,
        STOP
    } state_t;

    state_t          state_reg,     state_next;
    logic [1:0]      quarter_reg,   quarter_next;
    logic [QW-1:0]   qcnt_reg,      qcnt_next;
    logic [3:0]      bit_reg,       bit_next;
    logic [7:0]      shift_reg,     shift_next;
    logic [7:0]      data_reg,      data_next;
    logic            nack_reg,      nack_next;
    logic            scl_reg,       scl_next;
    logic            sda_reg,       sda_next;
    logic            ready_reg,     ready_next;
    logic            busy_reg,      busy_next;
    logic            done_reg,      done_next;
    logic            ack_error_reg, ack_error_next;

    logic quarter_end;
    logic bit_end;
    logic sample_point;

    assign quarter_end  = (qcnt_reg == Q_LAST);
    assign bit_end      = quarter_end && (quarter_reg == 2'd3);
    assign sample_point = quarter_end && (quarter_reg == 2'd2);

    assign tx_ready  = ready_reg;
    assign scl       = scl_reg;
    assign sda_o     = sda_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign ack_error = ack_error_reg;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            quarter_reg   <= 2'd0;
            qcnt_reg      <= '0;
            bit_reg       <= 4'd0;
            shift_reg     <= 8'd0;
            data_reg      <= 8'd0;
            nack_reg      <= 1'b0;
            scl_reg       <= 1'b1;
            sda_reg       <= 1'b1;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            ack_error_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            quarter_reg   <= quarter_next;
            qcnt_reg      <= qcnt_next;
            bit_reg       <= bit_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            nack_reg      <= nack_next;
            scl_reg       <= scl_next;
            sda_reg       <= sda_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            ack_error_reg <= ack_error_next;
        end
    end

    // Next-state sequencing, then line levels for the quarter being entered.
    always_comb begin
        state_next     = state_reg;
        quarter_next   = quarter_reg;
        qcnt_next      = qcnt_reg;
        bit_next       = bit_reg;
        shift_next     = shift_reg;
        data_next      = data_reg;
        nack_next      = nack_reg;
        ready_next     = ready_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        ack_error_next = 1'b0;
        scl_next       = 1'b1;
        sda_next       = 1'b1;

        if (state_reg == IDLE) begin
            if (tx_valid && ready_reg) begin
                state_next   = START;
                quarter_next = 2'd0;
                qcnt_next    = '0;
                bit_next     = 4'd0;
                shift_next   = ADDR_BYTE;
                data_next    = tx_data;
                nack_next    = 1'b0;
                ready_next   = 1'b0;
                busy_next    = 1'b1;
            end
        end else begin
            qcnt_next = quarter_end ? '0 : qcnt_reg + QW'(1);
            if (quarter_end) begin
                quarter_next = quarter_reg + 2'd1;
            end

            case (state_reg)
                START: begin
                    if (bit_end) begin
                        state_next = ADDR_TX;
                        bit_next   = 4'd0;
                    end
                end
                ADDR_TX, DATA_TX: begin
                    if (bit_end) begin
                        if (bit_reg == 4'd7) begin
                            bit_next   = 4'd0;
                            state_next = (state_reg == ADDR_TX) ? ADDR_ACK : DATA_ACK;
                        end else begin
                            bit_next   = bit_reg + 4'd1;
                            shift_next = {shift_reg[6:0], 1'b0};
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // A released (high) line at the sample point is a NACK.
                    if (sample_point) begin
                        nack_next      = sda_in;
                        ack_error_next = sda_in;
                    end
                    if (bit_end) begin
                        if ((state_reg == ADDR_ACK) && !nack_reg) begin
                            state_next = DATA_TX;
                            shift_next = data_reg;
                        end else begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    done_next = (quarter_reg == 2'd3) && (qcnt_reg == Q_PRE);
                    if (bit_end) begin
                        state_next = IDLE;
                        ready_next = 1'b1;
                        busy_next  = 1'b0;
                        qcnt_next  = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                end
            endcase
        end

        case (state_next)
            START: begin
                scl_next = (quarter_next != 2'd3);
                sda_next = (quarter_next == 2'd0);
            end
            ADDR_TX, DATA_TX: begin
                scl_next = (quarter_next == 2'd1) || (quarter_next == 2'd2);
                sda_next = shift_next[7];
            end
            ADDR_ACK, DATA_ACK: begin
                scl_next = (quarter_next == 2'd1) || (quarter_next == 2'd2);
                sda_next = 1'b1;
            end
            STOP: begin
                scl_next = (quarter_next != 2'd0);
                sda_next = quarter_next[1];
            end
            default: begin
                scl_next = 1'b1;
                sda_next = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_i2c_byte_tx.sv
// Self-checking bench for lcd_i2c_byte_tx (QUARTER=4, ADDR=7'h27).
// A bus-level slave model decodes bytes on SCL rising edges, spots
// START/STOP conditions and drives ACK/NACK; frame timing expectations
// are computed from quarter counts of the frame structure.
module tb_lcd_i2c_byte_tx;

    localparam int         Q       = 4;
    localparam logic [6:0] ADR     = 7'h27;
    localparam int         START_Q = 4;
    localparam int         BYTE_Q  = 36;
    localparam int         STOP_Q  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       scl;
    logic       sda_o;
    logic       sda_in;
    logic       busy;
    logic       done;
    logic       ack_error;

    logic slave_pull = 1'b0;
    bit   ack_addr   = 1'b1;
    bit   ack_data   = 1'b1;

    // Open-drain bus: either side may pull low.
    assign sda_in = sda_o & ~slave_pull;

    always #5 clock = ~clock;

    lcd_i2c_byte_tx #(.QUARTER(Q), .ADDR(ADR)) dut (
        .clock     (clock),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .scl       (scl),
        .sda_o     (sda_o),
        .sda_in    (sda_in),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error)
    );

    int passed = 0;
    int total  = 0;

    // Edge counter and accept detector.
    int edge_cnt    = 0;
    int accept_edge = 0;
    int accept_cnt  = 0;

    always @(posedge clock) begin
        edge_cnt <= edge_cnt + 1;
        if (!reset && tx_valid && tx_ready) begin
            accept_edge <= edge_cnt + 1;
            accept_cnt  <= accept_cnt + 1;
        end
    end

    // Slave model and bus event monitor.
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         bitn = 0;
    int         byte_idx = 0;
    logic [7:0] cur = 8'd0;
    logic [7:0] rx_bytes[$];
    int         start_total = 0;
    int         stop_total = 0;
    int         glitch_total = 0;
    int         done_total = 0;
    int         done_edge = 0;
    int         err_total = 0;
    int         err_edge = 0;

    always @(negedge clock) begin
        scl_p <= scl;
        sda_p <= sda_in;
        if (reset) begin
            bitn       <= 0;
            byte_idx   <= 0;
            slave_pull <= 1'b0;
        end else begin
            if (done) begin
                done_total <= done_total + 1;
                done_edge  <= edge_cnt;
            end
            if (ack_error) begin
                err_total <= err_total + 1;
                err_edge  <= edge_cnt;
            end
            if ((scl != scl_p) && (sda_in != sda_p)) begin
                glitch_total <= glitch_total + 1;
            end
            if (scl && scl_p && sda_p && !sda_in) begin
                start_total <= start_total + 1;
                bitn        <= 0;
                byte_idx    <= 0;
                slave_pull  <= 1'b0;
            end else if (scl && scl_p && !sda_p && sda_in) begin
                stop_total <= stop_total + 1;
                bitn       <= 0;
                slave_pull <= 1'b0;
            end else if (scl && !scl_p) begin
                if (bitn < 8) begin
                    cur <= {cur[6:0], sda_in};
                    if (bitn == 7) rx_bytes.push_back({cur[6:0], sda_in});
                    bitn <= bitn + 1;
                end else if (bitn == 8) begin
                    bitn <= 9;
                end
            end else if (!scl && scl_p) begin
                if (bitn == 8) begin
                    slave_pull <= (byte_idx == 0) ? ack_addr : ack_data;
                end else if (bitn == 9) begin
                    slave_pull <= 1'b0;
                    bitn       <= 0;
                    byte_idx   <= byte_idx + 1;
                end
            end
        end
    end

    typedef struct {
        int rx;
        int st;
        int sp;
        int gl;
        int dn;
        int er;
        int acc;
    } snap_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic snap_t take_snap();
        snap_t s;
        s.rx  = rx_bytes.size();
        s.st  = start_total;
        s.sp  = stop_total;
        s.gl  = glitch_total;
        s.dn  = done_total;
        s.er  = err_total;
        s.acc = accept_cnt;
        return s;
    endfunction

    function automatic logic [31:0] rx_at(input int idx);
        if (idx < rx_bytes.size()) return 32'(rx_bytes[idx]);
        return 32'hFFFF;
    endfunction

    task automatic wait_accept(input int base);
        int n = 0;
        while (accept_cnt == base && n < 50) begin
            step();
            n++;
        end
        check("accept_seen", 32'(accept_cnt - base), 32'd1);
        check("ready_after_accept", 32'(tx_ready), 32'd0);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_total == base && n < 1000) begin
            step();
            n++;
        end
        check("done_seen", 32'(done_total - base), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
        check("ready_at_done", 32'(tx_ready), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_scl"}, 32'(scl), 32'd1);
        check({tag, "_sda"}, 32'(sda_o), 32'd1);
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Clock numbering: clock 1 is the cycle right after the accept edge.
    task automatic check_frame(input logic [7:0] d, input bit aa, input bit ad,
                               input snap_t s, input int acc_e);
        int exp_rx      = aa ? 2 : 1;
        int exp_done    = Q * (START_Q + BYTE_Q + (aa ? BYTE_Q : 0) + STOP_Q);
        int exp_err     = (!aa || !ad) ? 1 : 0;
        int exp_err_clk = Q * (START_Q + (aa ? 2 * BYTE_Q : BYTE_Q) - 1) + 1;
        check("rx_count", 32'(rx_bytes.size() - s.rx), 32'(exp_rx));
        check("addr_byte", rx_at(s.rx), 32'h4E);
        if (aa) check("data_byte", rx_at(s.rx + 1), 32'(d));
        check("start_count", 32'(start_total - s.st), 32'd1);
        check("stop_count", 32'(stop_total - s.sp), 32'd1);
        check("sda_scl_same_edge", 32'(glitch_total - s.gl), 32'd0);
        check("done_clock", 32'(done_edge - acc_e + 1), 32'(exp_done));
        check("ack_error_count", 32'(err_total - s.er), 32'(exp_err));
        if (exp_err == 1) check("ack_error_clock", 32'(err_edge - acc_e + 1), 32'(exp_err_clk));
        $display("frame data=0x%02h ack_addr=%0d ack_data=%0d done_clock=%0d", d, aa, ad, done_edge - acc_e + 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit aa, input bit ad);
        snap_t s;
        int    a_e;
        ack_addr = aa;
        ack_data = ad;
        s        = take_snap();
        tx_data  = d;
        tx_valid = 1'b1;
        wait_accept(s.acc);
        a_e      = accept_edge;
        tx_valid = 1'b0;
        tx_data  = ~d;
        wait_done(s.dn);
        step();
        check_idle("after_frame");
        check_frame(d, aa, ad, s, a_e);
    endtask

    initial begin
        snap_t s1, s2;
        int    a1, a2, d1_edge;
        bit    aa, ad;
        logic [7:0] d;

        // Reset and idle.
        repeat (5) step();
        check_idle("reset");
        check("reset_done", 32'(done), 32'd0);
        check("reset_ack_error", 32'(ack_error), 32'd0);
        reset = 1'b0;
        s1 = take_snap();
        repeat (20) step();
        check_idle("idle20");
        check("idle_no_done", 32'(done_total - s1.dn), 32'd0);
        check("idle_no_ack_error", 32'(err_total - s1.er), 32'd0);
        check("idle_no_start", 32'(start_total - s1.st), 32'd0);

        // Directed frames.
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h77, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);

        // Back-to-back with tx_valid held high.
        ack_addr = 1'b1;
        ack_data = 1'b1;
        s1 = take_snap();
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        wait_accept(s1.acc);
        a1 = accept_edge;
        tx_data = 8'hFF;
        wait_done(s1.dn);
        d1_edge = done_edge;
        step();
        check_frame(8'h01, 1'b1, 1'b1, s1, a1);
        s2 = take_snap();
        wait_accept(s2.acc);
        a2 = accept_edge;
        tx_valid = 1'b0;
        // done is visible in clock d1_edge+1; accept must be one clock later.
        check("b2b_accept_gap", 32'(a2 - (d1_edge + 1)), 32'd1);
        wait_done(s2.dn);
        step();
        check_idle("after_b2b");
        check_frame(8'hFF, 1'b1, 1'b1, s2, a2);

        // Randomised frames.
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom_range(0, 255));
            aa = ($urandom_range(0, 3) != 0);
            ad = ($urandom_range(0, 2) != 0);
            send_frame(d, aa, ad);
        end

        // Reset in the middle of a frame.
        ack_addr = 1'b1;
        ack_data = 1'b1;
        s1 = take_snap();
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        wait_accept(s1.acc);
        a1 = accept_edge;
        tx_valid = 1'b0;
        while (edge_cnt - a1 + 1 < 100) step();
        check("busy_mid_frame", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        check_idle("mid_reset");
        check("mid_reset_done", 32'(done), 32'd0);
        check("mid_reset_ack_error", 32'(ack_error), 32'd0);
        reset = 1'b0;
        repeat (400) step();
        check("abort_no_done", 32'(done_total - s1.dn), 32'd0);
        check("abort_no_ack_error", 32'(err_total - s1.er), 32'd0);
        $display("reset at clock 100 of frame 0x5A: frame dropped");
        send_frame(8'hC3, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
